// File: rtl/mcu_bus_slave_if.sv
// mcu_bus_slave_if: MCU multiplexed-bus pads plus register-file side of the bus responder.
// Ports: ale/read/write (active-low pad strobes), data_in/data_out/data_oe (bidir pad halves),
//        addr/wr_data/wr_strobe/rd_strobe/rd_data (register file side), bus_error (sticky flag).
interface mcu_bus_slave_if;
  logic       ale;
  logic       read;
  logic       write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic       rd_strobe;
  logic [7:0] rd_data;
  logic       bus_error;

  modport slave (
    input  ale, read, write, data_in, rd_data,
    output data_out, data_oe, addr, wr_data, wr_strobe, rd_strobe, bus_error
  );

  modport master (
    output ale, read, write, data_in, rd_data,
    input  data_out, data_oe, addr, wr_data, wr_strobe, rd_strobe, bus_error
  );
endinterface

// File: rtl/mcu_bus_slave.sv
// Purpose: FPGA responder for the MCU multiplexed 8-bit bus; latches address, prefetches reads, commits writes.
// Latency: wr_strobe SYNC_STAGES+1 clk after write rises; rd_strobe SYNC_STAGES+1 clk after ale rises.
// Backpressure: none; the MCU sets the pace, a read arriving before the prefetch completes sets bus_error.
// Ports: clk, reset (async active-high), bus (mcu_bus_slave_if.slave: pads + register-file side).
// Optional: define MCU_BUS_AUTOINC_EN for address auto-increment after each write strobe / read.
module mcu_bus_slave #(
  parameter int SYNC_STAGES = 2,  // minimum 2
  parameter int RD_LATENCY  = 1   // 0 or 1
) (
  input  logic           clk,
  input  logic           reset,
  mcu_bus_slave_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_PREFETCH, ST_READY} state_t;

  localparam logic LAT_LAST = (RD_LATENCY != 0);

  // ---------------- input synchronisers ----------------
  logic [SYNC_STAGES-1:0]      ale_sq, rd_sq, wr_sq;
  logic [SYNC_STAGES-1:0][7:0] dat_sq;
  logic                        ale_pq, rd_pq, wr_pq;

  // write chain resets to "active" so a write already in progress at reset
  // never shows a falling edge and therefore can never be armed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ale_sq <= '1;
      rd_sq  <= '1;
      wr_sq  <= '0;
      dat_sq <= '0;
      ale_pq <= 1'b1;
      rd_pq  <= 1'b1;
      wr_pq  <= 1'b0;
    end else begin
      ale_sq <= {ale_sq[SYNC_STAGES-2:0], bus.ale};
      rd_sq  <= {rd_sq[SYNC_STAGES-2:0], bus.read};
      wr_sq  <= {wr_sq[SYNC_STAGES-2:0], bus.write};
      dat_sq <= {dat_sq[SYNC_STAGES-2:0], bus.data_in};
      ale_pq <= ale_sq[SYNC_STAGES-1];
      rd_pq  <= rd_sq[SYNC_STAGES-1];
      wr_pq  <= wr_sq[SYNC_STAGES-1];
    end
  end

  logic       ale_s, rd_s, wr_s;
  logic [7:0] dat_s;
  logic       ale_rise, rd_fall, wr_fall, wr_rise;

  assign ale_s    = ale_sq[SYNC_STAGES-1];
  assign rd_s     = rd_sq[SYNC_STAGES-1];
  assign wr_s     = wr_sq[SYNC_STAGES-1];
  assign dat_s    = dat_sq[SYNC_STAGES-1];
  assign ale_rise = ale_s & ~ale_pq;
  assign rd_fall  = ~rd_s & rd_pq;
  assign wr_fall  = ~wr_s & wr_pq;
  assign wr_rise  = wr_s & ~wr_pq;

`ifdef MCU_BUS_AUTOINC_EN
  logic rd_rise;
  assign rd_rise = rd_s & ~rd_pq;
`endif

  // ---------------- state and datapath ----------------
  state_t     state_q, state_d;
  logic       lat_q, lat_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] acap_q, acap_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] wcap_q, wcap_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_arm_q, wr_arm_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       rd_strobe_q, rd_strobe_d;
  logic       bus_error_q, bus_error_d;
  logic       pf_done;

  assign pf_done = (state_q == ST_PREFETCH) && (lat_q == LAT_LAST);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!ale_s) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (ale_rise) state_d = ST_PREFETCH;
      end
      ST_PREFETCH: begin
        if (!ale_s)       state_d = ST_ADDR;
        else if (pf_done) state_d = ST_READY;
      end
      ST_READY: begin
        if (!ale_s) state_d = ST_ADDR;
`ifdef MCU_BUS_AUTOINC_EN
        else if (rd_rise) state_d = ST_PREFETCH;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // output / datapath next-state logic
  always_comb begin
    addr_d      = addr_q;
    acap_d      = acap_q;
    hold_d      = hold_q;
    wcap_d      = wcap_q;
    wr_data_d   = wr_data_q;
    wr_arm_d    = wr_arm_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    bus_error_d = bus_error_q;
    lat_d       = 1'b0;

    // address phase: keep the most recent data seen while ale is low
    if (!ale_s) acap_d = dat_s;

`ifdef MCU_BUS_AUTOINC_EN
    // burst: step past the address that was just written
    if (wr_strobe_q) addr_d = addr_d + 8'd1;
    if ((state_q == ST_READY) && ale_s && rd_rise) begin
      addr_d      = addr_d + 8'd1;
      rd_strobe_d = 1'b1;
    end
`endif

    // a fresh address phase overrides any increment in the same cycle
    if ((state_q == ST_ADDR) && ale_rise) begin
      addr_d      = acap_q;
      rd_strobe_d = 1'b1;
    end

    if (state_q == ST_PREFETCH) begin
      lat_d = lat_q + 1'b1;
      if (pf_done) hold_d = bus.rd_data;
    end

    // write path: a write is armed only by a falling edge seen with ale high,
    // and any ale-low period drops it.
    if (!wr_s) wcap_d = dat_s;
    if (!ale_s)       wr_arm_d = 1'b0;
    else if (wr_fall) wr_arm_d = 1'b1;

    if (wr_rise && wr_arm_q && ale_s) begin
      wr_data_d   = wcap_q;
      wr_strobe_d = 1'b1;
      wr_arm_d    = 1'b0;
      // the write always targets addr_q, which is what hold_q mirrors, so
      // read-after-write sees the new value (and beats a same-cycle prefetch)
      hold_d      = wcap_q;
    end

    // early read: the hold register still has the previous address' data
    if (rd_fall && ((state_q == ST_ADDR) || (state_q == ST_PREFETCH))) bus_error_d = 1'b1;
    // read and write low together: write wins, flag the collision
    if (!rd_s && !wr_s) bus_error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_q       <= 1'b0;
      addr_q      <= '0;
      acap_q      <= '0;
      hold_q      <= '0;
      wcap_q      <= '0;
      wr_data_q   <= '0;
      wr_arm_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      lat_q       <= lat_d;
      addr_q      <= addr_d;
      acap_q      <= acap_d;
      hold_q      <= hold_d;
      wcap_q      <= wcap_d;
      wr_data_q   <= wr_data_d;
      wr_arm_q    <= wr_arm_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      bus_error_q <= bus_error_d;
    end
  end

  // read low lasts about one clk, so the pad enable follows the raw read pin;
  // raw ale/write low force it off to avoid fighting the MCU.
  assign bus.data_oe   = (state_q != ST_IDLE) & ~bus.read & bus.ale & bus.write;
  assign bus.data_out  = hold_q;
  assign bus.addr      = addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.rd_strobe = rd_strobe_q;
  assign bus.bus_error = bus_error_q;

endmodule

// File: tb/tb_mcu_bus_slave.sv
// tb_mcu_bus_slave: directed bench for mcu_bus_slave (SYNC_STAGES=2, RD_LATENCY=1).
// Models the MCU pads and a simple 256-byte register file with one-cycle read latency.
`timescale 1ns/1ps
module tb_mcu_bus_slave;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mcu_bus_slave_if bus ();

  mcu_bus_slave #(.SYNC_STAGES(SYNC), .RD_LATENCY(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #34 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // register file model
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] rd_q = 8'h00;
  always @(posedge clk) begin
    if (bus.wr_strobe) mem[bus.addr] <= bus.wr_data;
    if (bus.rd_strobe) rd_q <= mem[bus.addr];
  end
  assign bus.rd_data = rd_q;

  // strobe and contention monitors
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         oe_bad = 0;
  int         wr_cyc = 0;
  logic [7:0] wr_addr_seen = 8'h00;
  logic [7:0] wr_data_seen = 8'h00;
  always @(negedge clk) begin
    if (bus.wr_strobe) begin
      wr_cnt++;
      wr_cyc       = cyc;
      wr_addr_seen = bus.addr;
      wr_data_seen = bus.wr_data;
    end
    if (bus.rd_strobe) rd_cnt++;
    if (bus.data_oe && (!bus.ale || !bus.write)) oe_bad++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ale low for two clks with address on data; returns just after ale rises
  task automatic addr_phase(input logic [7:0] a);
    tick(1);
    bus.ale     = 1'b0;
    bus.data_in = a;
    tick(2);
    bus.ale     = 1'b1;
    bus.data_in = 8'h00;
  endtask

  // write low for two clks; returns rise cycle
  task automatic write_phase(input logic [7:0] d, output int rise_cyc);
    tick(1);
    bus.write   = 1'b0;
    bus.data_in = d;
    tick(2);
    bus.write   = 1'b1;
    bus.data_in = 8'h00;
    rise_cyc    = cyc;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_data_out"},  bus.data_out, 0);
    chk({tag, "_data_oe"},   bus.data_oe, 0);
    chk({tag, "_addr"},      bus.addr, 0);
    chk({tag, "_wr_data"},   bus.wr_data, 0);
    chk({tag, "_wr_strobe"}, bus.wr_strobe, 0);
    chk({tag, "_rd_strobe"}, bus.rd_strobe, 0);
    chk({tag, "_bus_error"}, bus.bus_error, 0);
  endtask

  typedef struct {
    bit         is_wr;
    logic [7:0] a;
    logic [7:0] d;   // write data, or expected read data
  } vec_t;

  initial begin
    vec_t       tbl [10];
    int         wc0;
    int         rc0;
    int         rise_cyc;
    logic [7:0] stale;
    logic [7:0] ai_d [3];
    logic [7:0] ai_a [3];

    tbl[0] = '{1'b1, 8'h10, 8'hE5};
    tbl[1] = '{1'b1, 8'h12, 8'h3C};
    tbl[2] = '{1'b0, 8'h12, 8'h3C};
    tbl[3] = '{1'b1, 8'h00, 8'h01};
    tbl[4] = '{1'b0, 8'h00, 8'h01};
    tbl[5] = '{1'b0, 8'h10, 8'hE5};
    tbl[6] = '{1'b1, 8'h12, 8'hA5};
    tbl[7] = '{1'b0, 8'h12, 8'hA5};
    tbl[8] = '{1'b1, 8'hFF, 8'h5A};
    tbl[9] = '{1'b0, 8'hFF, 8'h5A};

    bus.ale     = 1'b1;
    bus.read    = 1'b1;
    bus.write   = 1'b1;
    bus.data_in = 8'h00;

    #10;
    check_outputs_zero("reset");
    @(posedge clk);
    #2 reset = 1'b0;
    tick(2);

    // ---- table-driven writes and reads ----
    for (int i = 0; i < 10; i++) begin
      wc0 = wr_cnt;
      rc0 = rd_cnt;
      addr_phase(tbl[i].a);
      if (tbl[i].is_wr) begin
        write_phase(tbl[i].d, rise_cyc);
        tick(SYNC + 2);
        chk("wr_count",   wr_cnt - wc0, 1);
        chk("wr_latency", wr_cyc - rise_cyc, SYNC + 1);
        chk("wr_addr",    wr_addr_seen, tbl[i].a);
        chk("wr_data",    wr_data_seen, tbl[i].d);
      end else begin
        tick(6);
        chk("rd_strobe_count", rd_cnt - rc0, 1);
        bus.read = 1'b0;
        @(negedge clk);
        chk("rd_data_oe_low",  bus.data_oe, 1);
        chk("rd_data_out",     bus.data_out, tbl[i].d);
        tick(1);
        bus.read = 1'b1;
        @(negedge clk);
        chk("rd_data_oe_high", bus.data_oe, 0);
        chk("rd_bus_error",    bus.bus_error, 0);
      end
    end

    // ---- glitch on write shorter than a clock: never sampled ----
    wc0 = wr_cnt;
    tick(1);
    bus.write = 1'b0;
    #20;
    bus.write = 1'b1;
    tick(6);
    chk("glitch_no_strobe", wr_cnt - wc0, 0);

    // ---- ale low during an active write drops the write ----
    wc0 = wr_cnt;
    addr_phase(8'h50);
    tick(1);
    bus.write   = 1'b0;
    bus.data_in = 8'h66;
    tick(2);
    bus.ale     = 1'b0;
    bus.data_in = 8'h51;
    tick(2);
    bus.write   = 1'b1;
    tick(1);
    bus.ale     = 1'b1;
    bus.data_in = 8'h00;
    tick(6);
    chk("ale_drop_no_strobe", wr_cnt - wc0, 0);
    chk("ale_drop_new_addr",  bus.addr, 8'h51);

    // ---- write then read without a new address phase ----
    addr_phase(8'h30);
    tick(6);
    wc0 = wr_cnt;
    write_phase(8'h77, rise_cyc);
    tick(5);
    chk("raw_wr_count", wr_cnt - wc0, 1);
    bus.read = 1'b0;
    @(negedge clk);
    chk("raw_data_out", bus.data_out, 8'h77);
    chk("raw_data_oe",  bus.data_oe, 1);
    tick(1);
    bus.read = 1'b1;
`ifdef MCU_BUS_AUTOINC_EN
    stale = 8'h00;
`else
    tick(4);
    bus.read = 1'b0;
    @(negedge clk);
    chk("repeat_read_data", bus.data_out, 8'h77);
    tick(1);
    bus.read = 1'b1;
    tick(4);
    chk("repeat_read_addr", bus.addr, 8'h30);
    stale = 8'h77;
`endif
    tick(2);
    chk("no_error_yet", bus.bus_error, 0);

    // ---- read one clk after ale rise: stale data driven, bus_error set ----
    addr_phase(8'h40);
    tick(1);
    bus.read = 1'b0;
    @(negedge clk);
    chk("early_rd_oe",    bus.data_oe, 1);
    chk("early_rd_stale", bus.data_out, stale);
    tick(1);
    bus.read = 1'b1;
    tick(4);
    chk("early_rd_error", bus.bus_error, 1);

    // sticky across a clean read
    addr_phase(8'h12);
    tick(6);
    bus.read = 1'b0;
    @(negedge clk);
    chk("sticky_rd_data", bus.data_out, 8'hA5);
    tick(1);
    bus.read = 1'b1;
    tick(2);
    chk("sticky_error", bus.bus_error, 1);

    // ---- reset pulsed mid-write ----
    wc0 = wr_cnt;
    addr_phase(8'h60);
    tick(1);
    bus.write   = 1'b0;
    bus.data_in = 8'h99;
    tick(1);
    reset = 1'b1;
    #5;
    check_outputs_zero("midwr_reset");
    tick(1);
    reset = 1'b0;
    tick(2);
    bus.write   = 1'b1;
    bus.data_in = 8'h00;
    tick(6);
    chk("midwr_no_strobe", wr_cnt - wc0, 0);

    // next write commits normally
    wc0 = wr_cnt;
    addr_phase(8'h20);
    write_phase(8'h55, rise_cyc);
    tick(SYNC + 2);
    chk("post_reset_wr_count",   wr_cnt - wc0, 1);
    chk("post_reset_wr_addr",    wr_addr_seen, 8'h20);
    chk("post_reset_wr_data",    wr_data_seen, 8'h55);
    chk("post_reset_wr_latency", wr_cyc - rise_cyc, SYNC + 1);

    // ---- read and write low together: write wins, error flagged ----
    tick(2);
    wc0 = wr_cnt;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.data_in = 8'h3E;
    @(negedge clk);
    chk("rw_collide_oe", bus.data_oe, 0);
    tick(2);
    bus.read    = 1'b1;
    bus.write   = 1'b1;
    bus.data_in = 8'h00;
    tick(6);
    chk("rw_collide_error",   bus.bus_error, 1);
    chk("rw_collide_wr_cnt",  wr_cnt - wc0, 1);
    chk("rw_collide_wr_data", wr_data_seen, 8'h3E);

`ifdef MCU_BUS_AUTOINC_EN
    // ---- burst writes with auto-increment across the 0xFF wrap ----
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    ai_d[0] = 8'hAA; ai_d[1] = 8'hBB; ai_d[2] = 8'hCC;
    ai_a[0] = 8'hFE; ai_a[1] = 8'hFF; ai_a[2] = 8'h00;
    addr_phase(8'hFE);
    for (int k = 0; k < 3; k++) begin
      wc0 = wr_cnt;
      write_phase(ai_d[k], rise_cyc);
      tick(SYNC + 3);
      chk("autoinc_wr_count", wr_cnt - wc0, 1);
      chk("autoinc_wr_addr",  wr_addr_seen, ai_a[k]);
      chk("autoinc_wr_data",  wr_data_seen, ai_d[k]);
    end
`else
    ai_d[0] = 8'h00; ai_a[0] = 8'h00;
`endif

    chk("oe_contention", oe_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
